ff_counter_bank: RTL and testbench

Parametrised bank of CHANNELS independent WIDTH-bit up/down counters for the Anlogic flip-flop mapping suite. It is the next generation of the single-bit toggle-FF test. It adds these FF variants:
- async active-low reset with a parametrised reset value
- configurable clock edge and enable polarity
- synchronous clear and parallel load
- wrap or saturate arithmetic
- registered terminal-count flags

Synthesis checks that every variant maps to native DFF primitives with CE/SR, with no LUT emulation of reset or enable.

---
 rtl/ff_counter_bank.sv | 102 ++++++++++
 tb/tb_ff_counter_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_counter_bank.sv
// Bank of independent up/down counters with clear, load, wrap/saturate and
// registered terminal-count flags; clock edge and enable polarity are parameters.
module ff_counter_bank #(
    parameter int          CHANNELS           = 4,
    parameter int          WIDTH              = 8,
    parameter logic [63:0] RESET_VALUE        = 64'd0,
    parameter bit          CLK_NEGEDGE        = 1'b0,
    parameter bit          ENABLE_ACTIVE_HIGH = 1'b1,
    parameter bit          SATURATE           = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    output logic                      any_tc
);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("ff_counter_bank: CHANNELS must be 1..16");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("ff_counter_bank: WIDTH must be 2..32");
    end
    if ((RESET_VALUE >> WIDTH) != 64'd0) begin : g_bad_reset_value
        $error("ff_counter_bank: RESET_VALUE does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] RST_CNT = RESET_VALUE[WIDTH-1:0];

    logic [CHANNELS*WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0]       tc_q, tc_d;
    logic                      any_tc_q, any_tc_d;
    logic [CHANNELS-1:0]       en_act;

    assign en_act   = ENABLE_ACTIVE_HIGH ? enable : ~enable;
    assign any_tc_d = |tc_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;
        logic             at_lim;
        logic             tc_nxt;

        assign cur    = count_q[i*WIDTH +: WIDTH];
        assign at_lim = dir[i] ? (&cur) : ~(|cur);

        // clear beats load beats counting; tc only rises on a limit step
        always_comb begin
            nxt    = cur;
            tc_nxt = 1'b0;
            if (clear[i]) begin
                nxt = '0;
            end else if (load[i]) begin
                nxt = load_value[i*WIDTH +: WIDTH];
            end else if (en_act[i]) begin
                tc_nxt = at_lim;
                if (!(SATURATE && at_lim)) begin
                    nxt = dir[i] ? cur + 1'b1 : cur - 1'b1;
                end
            end
        end

        assign count_d[i*WIDTH +: WIDTH] = nxt;
        assign tc_d[i]                   = tc_nxt;
    end

    if (CLK_NEGEDGE) begin : g_negedge
        always_ff @(negedge clk or negedge reset) begin
            if (!reset) begin
                count_q  <= {CHANNELS{RST_CNT}};
                tc_q     <= '0;
                any_tc_q <= 1'b0;
            end else begin
                count_q  <= count_d;
                tc_q     <= tc_d;
                any_tc_q <= any_tc_d;
            end
        end
    end else begin : g_posedge
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count_q  <= {CHANNELS{RST_CNT}};
                tc_q     <= '0;
                any_tc_q <= 1'b0;
            end else begin
                count_q  <= count_d;
                tc_q     <= tc_d;
                any_tc_q <= any_tc_d;
            end
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign any_tc = any_tc_q;

endmodule

// File: tb/tb_ff_counter_bank.sv
// Randomized check of two counter-bank configurations against a behavioural model:
// A = rising edge, active-high enable, wrap; B = falling edge, active-low enable, saturate.
module tb_ff_counter_bank;

    localparam int CH = 4;
    localparam int W  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic [CH-1:0]   en_a, clr_a, ld_a, dir_a, tc_a;
    logic [CH*W-1:0] lv_a, cnt_a;
    logic            any_a;
    logic [CH-1:0]   en_b, clr_b, ld_b, dir_b, tc_b;
    logic [CH*W-1:0] lv_b, cnt_b;
    logic            any_b;

    ff_counter_bank #(
        .CHANNELS(CH), .WIDTH(W), .RESET_VALUE(64'h5A),
        .CLK_NEGEDGE(1'b0), .ENABLE_ACTIVE_HIGH(1'b1), .SATURATE(1'b0)
    ) u_a (
        .clk(clk), .reset(reset), .enable(en_a), .clear(clr_a),
        .load(ld_a), .dir(dir_a), .load_value(lv_a),
        .count(cnt_a), .tc(tc_a), .any_tc(any_a)
    );

    ff_counter_bank #(
        .CHANNELS(CH), .WIDTH(W), .RESET_VALUE(64'h33),
        .CLK_NEGEDGE(1'b1), .ENABLE_ACTIVE_HIGH(1'b0), .SATURATE(1'b1)
    ) u_b (
        .clk(clk), .reset(reset), .enable(en_b), .clear(clr_b),
        .load(ld_b), .dir(dir_b), .load_value(lv_b),
        .count(cnt_b), .tc(tc_b), .any_tc(any_b)
    );

    int unsigned m_rv[2]  = '{32'h5A, 32'h33};
    bit          m_sat[2] = '{1'b0, 1'b1};
    bit          m_enh[2] = '{1'b1, 1'b0};
    int unsigned m_cnt[2][CH];
    bit          m_tc[2][CH];
    bit          m_any[2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < CH; i++) begin
                m_cnt[d][i] = m_rv[d];
                m_tc[d][i]  = 1'b0;
            end
            m_any[d] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int d, input logic [CH-1:0] en,
                                       input logic [CH-1:0] clr,
                                       input logic [CH-1:0] ld,
                                       input logic [CH-1:0] dr,
                                       input logic [CH*W-1:0] lv);
        bit new_any = 1'b0;
        for (int i = 0; i < CH; i++) new_any |= m_tc[d][i];
        for (int i = 0; i < CH; i++) begin
            int unsigned c   = m_cnt[d][i];
            bit          act = m_enh[d] ? en[i] : !en[i];
            bit          lim;
            m_tc[d][i] = 1'b0;
            if (clr[i]) c = 0;
            else if (ld[i]) c = 32'(lv[i*W +: W]);
            else if (act) begin
                lim = dr[i] ? (c == 255) : (c == 0);
                m_tc[d][i] = lim;
                if (!(lim && m_sat[d]))
                    c = dr[i] ? (c + 1) % 256 : (c + 255) % 256;
            end
            m_cnt[d][i] = c;
        end
        m_any[d] = new_any;
    endfunction

    task automatic check_dut(input int d);
        logic [CH*W-1:0] cv;
        logic [CH-1:0]   tv;
        logic            av;
        string           nm;
        cv = d ? cnt_b : cnt_a;
        tv = d ? tc_b : tc_a;
        av = d ? any_b : any_a;
        nm = d ? "B" : "A";
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("%s.cnt%0d", nm, i), 32'(cv[i*W +: W]), m_cnt[d][i]);
            chk($sformatf("%s.tc%0d", nm, i), 32'(tv[i]), 32'(m_tc[d][i]));
        end
        chk($sformatf("%s.any_tc", nm), 32'(av), 32'(m_any[d]));
    endtask

    // A updates on the rising edge, B on the falling edge; each is also
    // checked for staying put on the other edge.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_step(0, en_a, clr_a, ld_a, dir_a, lv_a);
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        if (reset) model_step(1, en_b, clr_b, ld_b, dir_b, lv_b);
        #1;
        check_dut(1);
        check_dut(0);
    endtask

    task automatic set_idle();
        en_a = '0; clr_a = '0; ld_a = '0; dir_a = '0; lv_a = '0;
        en_b = '1; clr_b = '0; ld_b = '0; dir_b = '0; lv_b = '0;
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'hFE;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic rand_inputs();
        en_a  = 4'($urandom) | 4'($urandom);
        clr_a = 4'($urandom) & 4'($urandom) & 4'($urandom);
        ld_a  = 4'($urandom) & 4'($urandom);
        dir_a = 4'($urandom);
        en_b  = 4'($urandom) & 4'($urandom);
        clr_b = 4'($urandom) & 4'($urandom) & 4'($urandom);
        ld_b  = 4'($urandom) & 4'($urandom);
        dir_b = 4'($urandom);
        for (int i = 0; i < CH; i++) begin
            lv_a[i*W +: W] = pick();
            lv_b[i*W +: W] = pick();
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        #1 reset = 1'b1;
    endtask

    initial begin
        set_idle();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("A.rst_cnt", cnt_a, 32'h5A5A5A5A);
        chk("B.rst_cnt", cnt_b, 32'h33333333);
        chk("A.rst_tc", {tc_a, any_a}, '0);
        check_dut(0);
        check_dut(1);
        en_a = '1;
        dir_a = '1;
        cycle();
        cycle();
        #1 reset = 1'b1;

        cycle();
        chk("A.first_up", 32'(cnt_a[7:0]), 32'h5B);

        set_idle();
        ld_a = 4'b0001; lv_a[7:0] = 8'hFE;
        cycle();
        ld_a = '0; en_a = 4'b0001; dir_a = 4'b0001;
        cycle();
        cycle();
        chk("A.wrap_tc0", 32'(tc_a[0]), 32'h1);
        cycle();
        chk("A.wrap_any", 32'(any_a), 32'h1);

        set_idle();
        ld_a = 4'b0100; lv_a[23:16] = 8'h10;
        cycle();
        clr_a = 4'b0100; lv_a[23:16] = 8'h77; en_a = 4'b0100; dir_a = 4'b0100;
        cycle();
        chk("A.clr_wins", 32'(cnt_a[23:16]), 32'h00);
        clr_a = '0;
        cycle();
        chk("A.load_no_inc", 32'(cnt_a[23:16]), 32'h77);

        set_idle();
        ld_b = 4'b0010; lv_b[15:8] = 8'h01;
        cycle();
        ld_b = '0; en_b = 4'b1101; dir_b = 4'b0000;
        repeat (3) cycle();
        chk("B.sat_tc1", 32'(tc_b[1]), 32'h1);
        chk("B.sat_cnt1", 32'(cnt_b[15:8]), 32'h00);
        en_b = '1;
        cycle();
        chk("B.sat_drop", 32'(tc_b[1]), 32'h0);
        dir_b = 4'b1111; en_b = 4'b0000;
        repeat (2) cycle();

        set_idle();
        ld_a = 4'b1000; lv_a[31:24] = 8'hFF;
        cycle();
        ld_a = '0; en_a = 4'b1000; dir_a = 4'b1000;
        @(posedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        chk("A.edge_rst_tc3", 32'(tc_a[3]), 32'h0);
        chk("A.edge_rst_cnt3", 32'(cnt_a[31:24]), 32'h5A);
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        #1 reset = 1'b1;

        repeat (400) begin
            rand_inputs();
            cycle();
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
